// File: rtl/riscv_alu_issue_if.sv
// rtl/riscv_alu_issue_if.sv - decode-side and ALU-side handshake bundle for riscv_alu_issue
interface riscv_alu_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_srca;
  logic [XLEN-1:0] out_srcb;
  logic            out_ainv;
  logic            out_binv;
  logic [2:0]      out_alusel;
  logic [4:0]      out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_srca, out_srcb, out_ainv, out_binv,
           out_alusel, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_srca, out_srcb, out_ainv, out_binv,
           out_alusel, out_rd, out_illegal
  );
endinterface

// File: rtl/riscv_alu_issue.sv
// rtl/riscv_alu_issue.sv - RV32I ALU issue stage: decode, operand build, 2-entry skid buffer
// Optional writeback forwarding enabled by defining ALU_ISSUE_FWD_EN.
module riscv_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  riscv_alu_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [4:0]      code;
    logic [4:0]      rd;
    logic            illegal;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  beat_t  head_q, skid_q, dec;
  logic   in_ready_q, out_valid_q;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, a, b;
  logic [4:0]      code;
  logic            legal, is_shift, is_slt;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u  = {bus.in_instr[31:12], 12'b0};

`ifdef ALU_ISSUE_FWD_EN
  assign rs1_val = (wb_valid && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : bus.in_rs1_data;
  assign rs2_val = (wb_valid && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : bus.in_rs2_data;
`else
  assign rs1_val = bus.in_rs1_data;
  assign rs2_val = bus.in_rs2_data;
`endif

  function automatic logic [4:0] f3_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:         f3_code = alt ? 5'b01010 : 5'b00010;
      3'b001:         f3_code = 5'b00110;
      3'b010, 3'b011: f3_code = 5'b01011;
      3'b100:         f3_code = 5'b00100;
      3'b101:         f3_code = alt ? 5'b00101 : 5'b00111;
      3'b110:         f3_code = 5'b00001;
      default:        f3_code = 5'b00000;
    endcase
  endfunction

  always_comb begin
    legal    = 1'b0;
    code     = 5'b00000;
    a        = '0;
    b        = '0;
    is_shift = 1'b0;
    is_slt   = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal    = (funct7 == 7'd0) ||
                   (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        code     = f3_code(funct3, funct7[5]);
        a        = rs1_val;
        b        = rs2_val;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_slt   = (funct3 == 3'b010);
      end
      OPC_OP_IMM: begin
        // funct7 only matters for shifts; ADDI never becomes SUB
        if (funct3 == 3'b001)      legal = (funct7 == 7'd0);
        else if (funct3 == 3'b101) legal = (funct7 == 7'd0) || (funct7 == F7_ALT);
        else                       legal = 1'b1;
        code     = f3_code(funct3, (funct3 == 3'b101) && funct7[5]);
        a        = rs1_val;
        b        = imm_i;
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
        is_slt   = (funct3 == 3'b010);
      end
      OPC_LUI: begin
        legal = 1'b1;
        code  = 5'b00010;
        b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        code  = 5'b00010;
        a     = bus.in_pc;
        b     = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // ALU shifts by all of SrcB, so keep only the shamt field
    if (is_shift) b = {{(XLEN-5){1'b0}}, b[4:0]};
    // flipping sign bits maps signed order onto the ALU's unsigned compare
    if (is_slt) begin
      a[XLEN-1] = ~a[XLEN-1];
      b[XLEN-1] = ~b[XLEN-1];
    end

    if (legal) dec = '{srca: a, srcb: b, code: code, rd: rd, illegal: 1'b0};
    else       dec = '{srca: '0, srcb: '0, code: 5'b00000, rd: rd, illegal: 1'b1};
  end

  logic accept, consume;
  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          head_q      <= dec;
          state       <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: begin
          if (accept && !consume) begin
            skid_q     <= dec;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (consume && !accept) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept && consume) begin
            head_q <= dec;
          end
        end
        TWO: if (consume) begin
          head_q     <= skid_q;
          state      <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_srca    = head_q.srca;
  assign bus.out_srcb    = head_q.srcb;
  assign bus.out_ainv    = head_q.code[4];
  assign bus.out_binv    = head_q.code[3];
  assign bus.out_alusel  = head_q.code[2:0];
  assign bus.out_rd      = head_q.rd;
  assign bus.out_illegal = head_q.illegal;

endmodule
